// File: rtl/cpu_defs.sv
// Shared datapath constants for the MIPS register file slice.
// Named register indices are kept here so decode and writeback agree on them.
package cpu_defs;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/decoder_5_32.sv
// Write-address decoder: turns a binary register index into a one-hot write enable.
// Register $0 can never be selected, so bit 0 is always low.
module decoder_5_32
    import cpu_defs::*;
#(
    parameter int ADDR_W = cpu_defs::ADDR_W
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [2**ADDR_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en && (addr != '0)) begin
            onehot[addr] = 1'b1;
        end
        onehot[0] = 1'b0;
    end

endmodule

// File: rtl/grf_demux_regfile.sv
// 32-entry general register file: one decoded write port, two combinational read
// ports with optional same-cycle write bypass, and registered write status.
module grf_demux_regfile
    import cpu_defs::*;
#(
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int ADDR_W = cpu_defs::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_idx
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  wsel;
    logic              commit;

    assign commit = we && (wa != '0);

    decoder_5_32 #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .en     (we),
        .addr   (wa),
        .onehot (wsel)
    );

    // Only the decoded register loads; entry 0 is cleared by reset and never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (BYPASS && commit && (ra1 == wa)) begin
            rd1 = wd;
        end
        if (ra1 == '0) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = regs[ra2];
        if (BYPASS && commit && (ra2 == wa)) begin
            rd2 = wd;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end
    end

    // wr_idx remembers the last committed write even through idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en  <= 1'b0;
            wr_idx <= '0;
        end else begin
            wr_en <= commit;
            if (commit) begin
                wr_idx <= wa;
            end
        end
    end

endmodule

// File: tb/tb_grf_demux_regfile.sv
// Scoreboard bench for grf_demux_regfile: a bypassing and a non-bypassing copy share
// the same stimulus; expectations are queued and compared by a separate monitor.
module tb_grf_demux_regfile;

    typedef enum {K_RD1, K_RD2, K_NB_RD1, K_NB_RD2, K_WR_EN, K_WR_IDX} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        wr_en, nb_wr_en;
    logic [4:0]  wr_idx, nb_wr_idx;

    exp_t exp_q[$];
    event check_ev;
    int   checks   = 0;
    int   failures = 0;

    grf_demux_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .wr_en  (wr_en),
        .wr_idx (wr_idx)
    );

    grf_demux_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (nb_rd1),
        .rd2    (nb_rd2),
        .wr_en  (nb_wr_en),
        .wr_idx (nb_wr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                  input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        we  = w;
        wa  = a;
        wd  = d;
        ra1 = r1;
        ra2 = r2;
    endtask

    task automatic expect_out(input kind_t k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        ->check_ev;
        #1;
    endtask

    // Monitor: drains every queued expectation against the outputs present now.
    initial begin
        forever begin
            @(check_ev);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = exp_q.pop_front();
                case (e.kind)
                    K_RD1:    act = rd1;
                    K_RD2:    act = rd2;
                    K_NB_RD1: act = nb_rd1;
                    K_NB_RD2: act = nb_rd2;
                    K_WR_EN:  act = {31'b0, wr_en};
                    default:  act = {27'b0, wr_idx};
                endcase
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    // Decoder must be one-hot on the addressed register and silent for $0 or we=0.
    always begin
        logic [31:0] exp_sel;
        @(negedge clk);
        #4;
        exp_sel = (we && (wa != 5'd0)) ? (32'd1 << wa) : 32'd0;
        checks++;
        if (dut.wsel !== exp_sel || !$onehot0(dut.wsel)) begin
            failures++;
            $display("[TB] FAIL decoder_onehot: got %h expected %h", dut.wsel, exp_sel);
        end
    end

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        ra1   = '0;
        ra2   = '0;
        #12;
        reset = 1'b0;

        for (int i = 1; i < 32; i++) begin
            apply_stimulus(1'b1, 5'(i), $urandom, 5'd0, 5'd0);
        end
        apply_stimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        expect_out(K_WR_EN, 32'd1, "preload_wr_en");
        expect_out(K_WR_IDX, 32'd31, "preload_wr_idx");
        check_output();

        // Reset pulse between clock edges must clear everything on its own.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        expect_out(K_WR_EN, 32'd0, "reset_wr_en");
        expect_out(K_WR_IDX, 32'd0, "reset_wr_idx");
        check_output();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            expect_out(K_RD1, 32'd0, "reset_rd1");
            expect_out(K_RD2, 32'd0, "reset_rd2");
            check_output();
        end

        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        #1;
        expect_out(K_RD1, 32'hDEADBEEF, "basic_bypass_rd1");
        expect_out(K_NB_RD1, 32'd0, "basic_nobypass_rd1_old");
        check_output();
        apply_stimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        #1;
        expect_out(K_RD1, 32'hDEADBEEF, "basic_rd1");
        expect_out(K_NB_RD1, 32'hDEADBEEF, "basic_nobypass_rd1");
        expect_out(K_WR_EN, 32'd1, "basic_wr_en");
        expect_out(K_WR_IDX, 32'd5, "basic_wr_idx");
        check_output();

        apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        expect_out(K_RD1, 32'd0, "zero_rd1_before");
        expect_out(K_RD2, 32'd0, "zero_rd2_before");
        expect_out(K_NB_RD1, 32'd0, "zero_nobypass_rd1_before");
        check_output();
        apply_stimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        expect_out(K_RD1, 32'd0, "zero_rd1_after");
        expect_out(K_WR_EN, 32'd0, "zero_wr_en");
        expect_out(K_WR_IDX, 32'd5, "zero_wr_idx_hold");
        check_output();

        apply_stimulus(1'b1, 5'd31, 32'h11111111, 5'd0, 5'd0);
        apply_stimulus(1'b1, 5'd31, 32'h00400004, 5'd31, 5'd31);
        #1;
        expect_out(K_RD2, 32'h00400004, "bypass_rd2");
        expect_out(K_RD1, 32'h00400004, "bypass_rd1");
        expect_out(K_NB_RD2, 32'h11111111, "nobypass_rd2_old");
        check_output();
        apply_stimulus(1'b0, 5'd31, 32'hDEAD0000, 5'd31, 5'd31);
        #1;
        expect_out(K_RD2, 32'h00400004, "bypass_rd2_after");
        expect_out(K_NB_RD2, 32'h00400004, "nobypass_rd2_after");
        expect_out(K_RD1, 32'h00400004, "no_bypass_when_we0");
        expect_out(K_WR_IDX, 32'd31, "bypass_wr_idx");
        check_output();

        for (int i = 1; i < 32; i++) begin
            apply_stimulus(1'b1, 5'(i), 32'(i * 4), 5'd0, 5'd0);
        end
        apply_stimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            expect_out(K_RD1, 32'(i * 4), "iso_rd1");
            expect_out(K_RD2, 32'((31 - i) * 4), "iso_rd2");
            expect_out(K_NB_RD1, 32'(i * 4), "iso_nobypass_rd1");
            check_output();
        end

        // Reset rises 1 time unit before the edge that would have taken the write.
        apply_stimulus(1'b1, 5'd7, 32'd1, 5'd7, 5'd0);
        #4;
        reset = 1'b1;
        @(negedge clk);
        we = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        expect_out(K_RD1, 32'd0, "midwrite_reg7");
        expect_out(K_NB_RD1, 32'd0, "midwrite_nobypass_reg7");
        expect_out(K_WR_EN, 32'd0, "midwrite_wr_en");
        expect_out(K_WR_IDX, 32'd0, "midwrite_wr_idx");
        check_output();

        apply_stimulus(1'b1, 5'd7, 32'h00000077, 5'd0, 5'd0);
        apply_stimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        #1;
        expect_out(K_RD1, 32'h00000077, "post_reset_write");
        expect_out(K_WR_EN, 32'd1, "post_reset_wr_en");
        expect_out(K_WR_IDX, 32'd7, "post_reset_wr_idx");
        check_output();

        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
